dmem_arbiter: RTL



---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter sharing one fixed-latency data-memory port.
// Define DMEM_ARB_CPU_PRIORITY_EN for fixed priority to port 0 instead of round-robin.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  // Cycles spent in WAIT before the capture cycle; RD_LAT = 1 captures in the first WAIT cycle.
  localparam logic [1:0] LatInit = 2'(RD_LAT - 1);

  state_e     state;
  logic       we_q;
  logic [1:0] cnt;
  logic       win;

`ifdef DMEM_ARB_CPU_PRIORITY_EN
  always_comb begin
    win = ~req0;
  end
`else
  logic ptr;

  // On a tie the port not granted last wins; a lone requester always wins.
  always_comb begin
    win = (req0 && req1) ? ~ptr : req1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      we_q      <= 1'b0;
      cnt       <= 2'd0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      gnt       <= 1'b0;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
      ptr       <= 1'b1;
`endif
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req0 || req1) begin
            state     <= StIssue;
            busy      <= 1'b1;
            gnt       <= win;
            we_q      <= win ? we1 : we0;
            mem_we    <= win ? we1 : we0;
            mem_addr  <= win ? addr1 : addr0;
            mem_wdata <= win ? wdata1 : wdata0;
          end
        end
        StIssue: begin
          if (we_q) begin
            state <= StDone;
            ack0  <= ~gnt;
            ack1  <= gnt;
          end else begin
            state <= StWait;
            cnt   <= LatInit;
          end
        end
        StWait: begin
          if (cnt == 2'd0) begin
            if (gnt) rdata1 <= mem_rdata;
            else     rdata0 <= mem_rdata;
            state <= StDone;
            ack0  <= ~gnt;
            ack1  <= gnt;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
          ptr   <= gnt;
`endif
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  ack_exclusive: assert property (@(posedge clk) disable iff (reset) !(ack0 && ack1));
  we_only_in_issue: assert property (@(posedge clk) mem_we |-> state == StIssue);

endmodule
